// File: rtl/lab8_soc_keyevent_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab8_soc_keyevent_pkg
//  Description : Shared constants for the key-event FIFO peripheral.
//                Holds the Avalon register addresses and the STATUS bit
//                positions used by the top level and by software drivers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lab8_soc_keyevent_pkg;

    // Avalon register map (word addresses)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_FLUSH   = 2'd3;

    // STATUS register layout: count occupies [15:0]
    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_IRQ   = 18;

    // Avalon data bus width
    localparam int BUS_W    = 32;

endpackage
`default_nettype wire

// File: rtl/keyevent_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : keyevent_sync_fifo
//  Description : Single-clock FIFO holding key events. Push/pop requests are
//                gated internally against full/empty, so callers may raise
//                them unconditionally. A flush clears pointers and count and
//                takes priority over a coincident push or pop.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                flush_i           - empty the FIFO at the next edge
//                push_i/push_data_i- write request and event data
//                pop_i             - read request (advances the head)
//                head_o            - entry at the read pointer
//                count_o           - occupancy 0..DEPTH
//                full_o/empty_o    - occupancy flags (registered state only)
//  Revision    : 1.0 - initial release
// ============================================================================
module keyevent_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    // DEPTH is a power of two, so pointer wrap is plain AW-bit overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    // A write during flush lands in a slot that the flush just abandoned.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lab8_soc_keyevent_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lab8_soc_keyevent_fifo
//  Description : Avalon-MM slave that buffers key events pushed by fabric
//                logic (valid/ready) and lets the CPU drain them by reading
//                DATA. Provides STATUS, an IRQ mask and a FLUSH command.
//  Ports       : clk, reset_n      - clock, asynchronous active-low reset
//                address           - register select (DATA/STATUS/IRQMASK/FLUSH)
//                chipselect, read_n, write_n, writedata, readdata
//                                  - Avalon slave, zero wait states
//                irq               - level interrupt: mask && not empty
//                in_data, in_valid, in_ready
//                                  - fabric event input handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module lab8_soc_keyevent_fifo
    import lab8_soc_keyevent_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             rd_sel;
    logic             wr_sel;
    logic             pop;
    logic             flush;
    logic             mask_q, mask_d;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic [31:0]      readdata_d;
    logic             unused_wdata;

    assign rd_sel = chipselect & ~read_n;
    assign wr_sel = chipselect & ~write_n;
    assign pop    = rd_sel & (address == ADDR_DATA);
    assign flush  = wr_sel & (address == ADDR_FLUSH);

    // Only bit 0 of writedata has a home (IRQMASK).
    assign unused_wdata = &{1'b0, writedata[31:1]};

    keyevent_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .flush_i     (flush),
        .push_i      (in_valid),
        .push_data_i (in_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // in_ready and irq come purely from registered state so fabric and CPU
    // never see a combinational path from the Avalon strobes.
    assign in_ready = ~full;
    assign irq      = mask_q & ~empty;

    always_comb begin
        mask_d = mask_q;
        if (wr_sel && (address == ADDR_IRQMASK)) begin
            mask_d = writedata[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Read mux: zero-latency, a function of address and registered state.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: begin
                if (!empty) begin
                    readdata_d[WIDTH-1:0] = head;
                end
            end
            ADDR_STATUS: begin
                readdata_d[CW-1:0]  = count;
                readdata_d[ST_EMPTY] = empty;
                readdata_d[ST_FULL]  = full;
                readdata_d[ST_IRQ]   = irq;
            end
            ADDR_IRQMASK: begin
                readdata_d[0] = mask_q;
            end
            default: begin
                readdata_d = '0;
            end
        endcase
    end

    assign readdata = readdata_d;

endmodule
`default_nettype wire
